// File: rtl/iotdf.sv
// IoT data filter: assembles 128-bit samples from 16 serial bytes and filters them per round of 8.
// Optional peak-tracking functions F6/F7 are built only when IOTDF_PEAK_EN is defined.
module iotdf (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic [7:0]   iot_in,
  input  logic [2:0]   fn_sel,
  output logic         busy,
  output logic         valid,
  output logic [127:0] iot_out
);

  localparam int unsigned DW = 128;
  localparam int unsigned SW = 131;
  localparam int unsigned BW = 8;

  localparam logic [DW-1:0] EXT_LOW  = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] EXT_HIGH = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] EXC_LOW  = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] EXC_HIGH = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  logic [DW-1:0] shift_q;
  logic [3:0]    byte_cnt;
  logic [2:0]    smp_cnt;
  logic          pend;
  logic [DW-1:0] max_q;
  logic [DW-1:0] min_q;
  logic [SW-1:0] sum_q;

  logic          first_c;
  logic          last_c;
  logic [DW-1:0] rnd_max_c;
  logic [DW-1:0] rnd_min_c;
  logic [SW-1:0] sum_nx_c;
  logic          hit_c;
  logic [DW-1:0] res_c;

`ifdef IOTDF_PEAK_EN
  logic [DW-1:0] peak_q;
  logic          peak_empty;
  logic          peak_upd_c;
`endif

  // The assembly register still holds the complete sample on the processing edge,
  // because the next shift lands on that same edge.
  assign first_c   = (smp_cnt == 3'd0);
  assign last_c    = (smp_cnt == 3'd7);
  assign rnd_max_c = (first_c || (shift_q > max_q)) ? shift_q : max_q;
  assign rnd_min_c = (first_c || (shift_q < min_q)) ? shift_q : min_q;
  assign sum_nx_c  = first_c ? SW'(shift_q) : (sum_q + SW'(shift_q));

  // Function select: decide whether this processed sample produces a result
  always_comb begin
    hit_c = 1'b0;
    res_c = shift_q;
`ifdef IOTDF_PEAK_EN
    peak_upd_c = 1'b0;
`endif
    case (fn_sel)
      3'd1: begin
        hit_c = last_c;
        res_c = rnd_max_c;
      end
      3'd2: begin
        hit_c = last_c;
        res_c = rnd_min_c;
      end
      3'd3: begin
        hit_c = last_c;
        res_c = sum_nx_c[SW-1:3];
      end
      3'd4: hit_c = (shift_q > EXT_LOW) && (shift_q < EXT_HIGH);
      3'd5: hit_c = (shift_q < EXC_LOW) || (shift_q > EXC_HIGH);
`ifdef IOTDF_PEAK_EN
      3'd6: begin
        res_c = rnd_max_c;
        if (last_c && (peak_empty || (rnd_max_c > peak_q))) begin
          hit_c      = 1'b1;
          peak_upd_c = 1'b1;
        end
      end
      3'd7: begin
        res_c = rnd_min_c;
        if (last_c && (peak_empty || (rnd_min_c < peak_q))) begin
          hit_c      = 1'b1;
          peak_upd_c = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Byte assembly, round accumulation and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      byte_cnt <= '0;
      smp_cnt  <= '0;
      pend     <= 1'b0;
      max_q    <= '0;
      min_q    <= '0;
      sum_q    <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      iot_out  <= '0;
    end else begin
      busy  <= 1'b0;
      valid <= 1'b0;
      pend  <= in_en && (byte_cnt == 4'd15);
      if (in_en) begin
        shift_q  <= {shift_q[DW-BW-1:0], iot_in};
        byte_cnt <= byte_cnt + 4'd1;
      end
      if (pend) begin
        max_q   <= rnd_max_c;
        min_q   <= rnd_min_c;
        sum_q   <= sum_nx_c;
        smp_cnt <= smp_cnt + 3'd1;
        if (hit_c) begin
          valid   <= 1'b1;
          iot_out <= res_c;
        end
      end
    end
  end

`ifdef IOTDF_PEAK_EN
  // Peak register persists across rounds until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q     <= '0;
      peak_empty <= 1'b1;
    end else if (pend && peak_upd_c) begin
      peak_q     <= res_c;
      peak_empty <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_iotdf.sv
// Self-checking bench for iotdf: directed vector table, corner sequences and randomized
// rounds checked against a behavioural model (peak cases follow IOTDF_PEAK_EN).
module tb_iotdf;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         busy;
  logic         valid;
  logic [127:0] iot_out;

  localparam logic [127:0] EXT_LOW  = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] EXT_HIGH = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] EXC_LOW  = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] EXC_HIGH = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  iotdf dut (
    .clk    (clk),
    .rst    (rst),
    .in_en  (in_en),
    .iot_in (iot_in),
    .fn_sel (fn_sel),
    .busy   (busy),
    .valid  (valid),
    .iot_out(iot_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] obs[$];
  logic [127:0] exp_q[$];

  // Behavioural model state
  bit           peak_known;
  logic [127:0] peak_val;

  always @(negedge clk) begin
    if (valid === 1'b1) obs.push_back(iot_out);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endtask

  task automatic do_reset(input logic [2:0] fn);
    @(negedge clk);
    rst = 1'b1; in_en = 1'b0; iot_in = '0; fn_sel = fn;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    peak_known = 1'b0;
    peak_val = '0;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(valid), 128'd0);
    check("rst_out", iot_out, 128'd0);
    obs.delete();
  endtask

  task automatic send_sample(input logic [127:0] s, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          in_en = 1'b0;
          iot_in = 8'($urandom);
        end
      end
      @(negedge clk);
      in_en = 1'b1;
      iot_in = s[127 - 8*i -: 8];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_en = 1'b0;
    end
  endtask

  // Reference model: expected results for a sample stream from the filter rules
  function automatic void model(input logic [2:0] fn, input logic [127:0] s[$]);
    logic [127:0] mx, mn;
    logic [130:0] sum;
    for (int i = 0; i < s.size(); i++) begin
      if (fn == 3'd4 && s[i] > EXT_LOW && s[i] < EXT_HIGH) exp_q.push_back(s[i]);
      if (fn == 3'd5 && (s[i] < EXC_LOW || s[i] > EXC_HIGH)) exp_q.push_back(s[i]);
      if (i % 8 == 7) begin
        mx = s[i]; mn = s[i]; sum = '0;
        for (int j = i - 7; j <= i; j++) begin
          if (s[j] > mx) mx = s[j];
          if (s[j] < mn) mn = s[j];
          sum = sum + 131'(s[j]);
        end
        case (fn)
          3'd1: exp_q.push_back(mx);
          3'd2: exp_q.push_back(mn);
          3'd3: exp_q.push_back(128'(sum / 131'd8));
`ifdef IOTDF_PEAK_EN
          3'd6: if (!peak_known || mx > peak_val) begin
                  exp_q.push_back(mx); peak_val = mx; peak_known = 1'b1;
                end
          3'd7: if (!peak_known || mn < peak_val) begin
                  exp_q.push_back(mn); peak_val = mn; peak_known = 1'b1;
                end
`endif
          default: ;
        endcase
      end
    end
  endfunction

  task automatic compare_obs(input string name);
    check({name, "_count"}, 128'(obs.size()), 128'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check({name, "_data"}, obs[i], exp_q[i]);
  endtask

  typedef struct {
    string                name;
    logic [2:0]           fn;
    int                   n;
    logic [23:0][127:0]   s;
    bit                   gaps;
    int                   exp_n;
    logic [2:0][127:0]    expv;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [127:0] sq[$];
    logic [127:0] ones;
    logic [7:0]   his[8];
    ones = '1;
    his = '{8'h6F, 8'h70, 8'h7F, 8'h80, 8'hAF, 8'hB0, 8'hBF, 8'hC0};
    rst = 1'b1; in_en = 1'b0; iot_in = '0; fn_sel = 3'd0;

    // Directed vector table
    v = '{default: '0};
    v.name = "f1_seq"; v.fn = 3'd1; v.n = 8; v.exp_n = 1; v.expv[0] = 128'd8;
    for (int j = 0; j < 8; j++) v.s[j] = 128'(j + 1);
    vecs.push_back(v);
    v.name = "f1_gaps"; v.gaps = 1'b1;
    vecs.push_back(v);
    v = '{default: '0};
    v.name = "f2_mix"; v.fn = 3'd2; v.n = 8; v.exp_n = 1; v.expv[0] = 128'd1;
    v.s[0] = 128'd5; v.s[1] = 128'd3; v.s[2] = 128'd9; v.s[3] = 128'd1;
    v.s[4] = 128'd7; v.s[5] = 128'd2; v.s[6] = ones; v.s[7] = 128'd6;
    vecs.push_back(v);
    v = '{default: '0};
    v.name = "f3_0to7"; v.fn = 3'd3; v.n = 8; v.exp_n = 1; v.expv[0] = 128'd3;
    for (int j = 0; j < 8; j++) v.s[j] = 128'(j);
    vecs.push_back(v);
    v = '{default: '0};
    v.name = "f3_ones"; v.fn = 3'd3; v.n = 8; v.exp_n = 1; v.expv[0] = ones;
    for (int j = 0; j < 8; j++) v.s[j] = ones;
    vecs.push_back(v);
    v = '{default: '0};
    v.name = "f4_bounds"; v.fn = 3'd4; v.n = 4; v.exp_n = 2;
    v.s[0] = EXT_LOW; v.s[1] = EXT_LOW + 128'd1; v.s[2] = EXT_HIGH; v.s[3] = EXT_HIGH - 128'd1;
    v.expv[0] = EXT_LOW + 128'd1; v.expv[1] = EXT_HIGH - 128'd1;
    vecs.push_back(v);
    v = '{default: '0};
    v.name = "f5_bounds"; v.fn = 3'd5; v.n = 4; v.exp_n = 2;
    v.s[0] = 128'd0; v.s[1] = EXC_LOW; v.s[2] = EXC_HIGH + 128'd1; v.s[3] = EXC_HIGH;
    v.expv[0] = 128'd0; v.expv[1] = EXC_HIGH + 128'd1;
    vecs.push_back(v);
    v = '{default: '0};
    v.name = "f6_peaks"; v.fn = 3'd6; v.n = 24;
    for (int r = 0; r < 3; r++) begin
      int m = (r == 0) ? 5 : (r == 1) ? 3 : 9;
      for (int j = 0; j < 8; j++) v.s[r*8 + j] = (j == 3) ? 128'(m) : 128'(j % m);
    end
`ifdef IOTDF_PEAK_EN
    v.exp_n = 2; v.expv[0] = 128'd5; v.expv[1] = 128'd9;
`endif
    vecs.push_back(v);
    v = '{default: '0};
    v.name = "f7_peaks"; v.fn = 3'd7; v.n = 24;
    for (int r = 0; r < 3; r++) begin
      int m = (r == 0) ? 5 : (r == 1) ? 7 : 2;
      for (int j = 0; j < 8; j++) v.s[r*8 + j] = (j == 3) ? 128'(m) : 128'(m + j + 1);
    end
`ifdef IOTDF_PEAK_EN
    v.exp_n = 2; v.expv[0] = 128'd5; v.expv[1] = 128'd2;
`endif
    vecs.push_back(v);
    v = '{default: '0};
    v.name = "f0_none"; v.fn = 3'd0; v.n = 8;
    for (int j = 0; j < 8; j++) v.s[j] = 128'(j);
    vecs.push_back(v);

    foreach (vecs[t]) begin
      do_reset(vecs[t].fn);
      for (int i = 0; i < vecs[t].n; i++) send_sample(vecs[t].s[i], vecs[t].gaps);
      idle(6);
      exp_q.delete();
      for (int i = 0; i < vecs[t].exp_n; i++) exp_q.push_back(vecs[t].expv[i]);
      compare_obs(vecs[t].name);
    end

    // Latency: valid in the cycle after the edge following the 128th byte, one cycle wide
    do_reset(3'd1);
    for (int j = 1; j <= 8; j++) send_sample(128'(j), 1'b0);
    @(negedge clk); in_en = 1'b0;
    check("lat_e", 128'(valid), 128'd0);
    @(negedge clk);
    check("lat_e1", 128'(valid), 128'd1);
    check("lat_out", iot_out, 128'd8);
    @(negedge clk);
    check("lat_drop", 128'(valid), 128'd0);
    check("lat_hold", iot_out, 128'd8);

    // Reset mid-round and mid-sample discards partial data
    do_reset(3'd1);
    for (int j = 0; j < 3; j++) send_sample(ones, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); in_en = 1'b1; iot_in = 8'hFF;
    end
    do_reset(3'd1);
    for (int j = 1; j <= 8; j++) send_sample(128'(j), 1'b1);
    idle(6);
    exp_q.delete(); exp_q.push_back(128'd8);
    compare_obs("rst_mid");

    // Randomized rounds against the model
    for (int f = 1; f <= 7; f++) begin
      for (int it = 0; it < 2; it++) begin
        do_reset(3'(f));
        sq.delete();
        for (int i = 0; i < 16; i++) begin
          logic [127:0] x;
          x = {$urandom, $urandom, $urandom, $urandom};
          if (f == 4 || f == 5) begin
            x[127:120] = his[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) x[119:0] = '1;
          end
          sq.push_back(x);
        end
        foreach (sq[i]) send_sample(sq[i], 1'($urandom_range(0, 1)));
        idle(6);
        exp_q.delete();
        model(3'(f), sq);
        compare_obs($sformatf("rand_f%0d", f));
      end
    end

    check("end_busy", 128'(busy), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
